// File: rtl/step_sequencer.sv
// Step sequencer: walks an index 0..NUM_STATES-1 while start is held, dwelling a
// programmable number of enabled cycles per step, with saturate/wrap/bounce end handling.
module step_sequencer #(
    parameter int NUM_STATES = 5,
    parameter int OUT_W      = 5,
    parameter int DWELL_W    = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               clear,
    input  logic [1:0]         mode,
    input  logic [DWELL_W-1:0] dwell,
    output logic [OUT_W-1:0]   out,
    output logic               ready,
    output logic               done,
    output logic               busy
);

    localparam int IDX_W = (NUM_STATES > 1) ? $clog2(NUM_STATES) : 1;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_STATES - 1);
    localparam logic [IDX_W-1:0] ONE  = IDX_W'(1);

    typedef enum logic [1:0] {
        MODE_SAT    = 2'd0,
        MODE_WRAP   = 2'd1,
        MODE_BOUNCE = 2'd2,
        MODE_RSVD   = 2'd3
    } mode_e;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_e;

    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [DWELL_W-1:0] dwell_cnt_q, dwell_cnt_d;
    dir_e               dir_q, dir_d;
    logic               done_q, done_d;

    mode_e              mode_s;
    logic               is_wrap;
    logic               is_bounce;
    logic               at_last;
    logic               at_first;
    logic               parked;
    logic               going_down;
    logic [IDX_W-1:0]   adv_idx;
    dir_e               adv_dir;

    assign mode_s    = mode_e'(mode);
    assign is_wrap   = (mode_s == MODE_WRAP);
    assign is_bounce = (mode_s == MODE_BOUNCE);
    assign at_last   = (idx_q == LAST);
    assign at_first  = (idx_q == '0);
    // Reserved mode falls into the saturate case because it is neither wrap nor bounce.
    assign parked    = at_last && !is_wrap && !is_bounce;

    // At LAST we always descend, even if we entered bounce from another mode with dir=up.
    assign going_down = at_last || ((dir_q == DIR_DOWN) && !at_first);

    // Index and direction that an advance would produce in the current mode.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        adv_idx = idx_q;
        adv_dir = DIR_UP;
        if (is_bounce) begin
            if (going_down) begin
                adv_idx = idx_q - ONE;
                adv_dir = (idx_q == ONE) ? DIR_UP : DIR_DOWN;
            end else begin
                adv_idx = idx_q + ONE;
                adv_dir = ((idx_q + ONE) == LAST) ? DIR_DOWN : DIR_UP;
            end
        end else if (is_wrap) begin
            adv_idx = at_last ? '0 : idx_q + ONE;
        end else if (!at_last) begin
            adv_idx = idx_q + ONE;
        end
    end

    always_comb begin
        idx_d       = idx_q;
        dwell_cnt_d = dwell_cnt_q;
        dir_d       = dir_q;
        done_d      = 1'b0;
        if (clear) begin
            idx_d       = '0;
            dwell_cnt_d = '0;
            dir_d       = DIR_UP;
        end else if (start) begin
            if (parked) begin
                dwell_cnt_d = '0;
            end else if (dwell_cnt_q < dwell) begin
                dwell_cnt_d = dwell_cnt_q + DWELL_W'(1);
            end else begin
                idx_d       = adv_idx;
                dir_d       = adv_dir;
                dwell_cnt_d = '0;
                done_d      = !at_last && (adv_idx == LAST);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        // NOTE: state registers use non-blocking assignments so all flops update together.
        if (reset) begin
            idx_q       <= '0;
            dwell_cnt_q <= '0;
            dir_q       <= DIR_UP;
            done_q      <= 1'b0;
        end else begin
            idx_q       <= idx_d;
            dwell_cnt_q <= dwell_cnt_d;
            dir_q       <= dir_d;
            done_q      <= done_d;
        end
    end

    // Zero-extend through a wide intermediate so any OUT_W, larger or smaller, works.
    logic [OUT_W+IDX_W-1:0] idx_ext;
    assign idx_ext = {{OUT_W{1'b0}}, idx_q};
    assign out     = idx_ext[OUT_W-1:0];
    assign ready   = at_last;
    assign done    = done_q;
    assign busy    = !parked;

endmodule
